// File: rtl/pmipsl_pkg.sv
// Shared PMIPSL pipeline definitions: default datapath widths, the fetch/decode
// hand-off entry layout and the opcode field encoding decode keys on.
package pmipsl_pkg;

    localparam int unsigned PMIPSL_ADDR_W  = 16;
    localparam int unsigned PMIPSL_INSTR_W = 17;
    localparam int unsigned PMIPSL_OPC_W   = 5;

    typedef struct packed {
        logic [PMIPSL_INSTR_W-1:0] instr;
        logic [PMIPSL_ADDR_W-1:0]  pcplus;
    } fetch_entry_t;

    typedef enum logic [PMIPSL_OPC_W-1:0] {
        OpAlu  = 5'h00,
        OpAddi = 5'h01,
        OpLw   = 5'h02,
        OpSw   = 5'h03,
        OpBeq  = 5'h04,
        OpBne  = 5'h05,
        OpJmp  = 5'h06,
        OpJal  = 5'h07,
        OpJr   = 5'h08,
        OpNop  = 5'h1f
    } opcode_e;

    // Opcode lives in the top bits of the instruction word.
    function automatic opcode_e instr_opcode(input logic [PMIPSL_INSTR_W-1:0] instr);
        return opcode_e'(instr[PMIPSL_INSTR_W-1 -: PMIPSL_OPC_W]);
    endfunction

endpackage

// File: rtl/pmipsl_fetch_fifo.sv
// Prefetch queue: synchronous FIFO with a flush that overrides push/pop in the
// same cycle, an occupancy count and a zeroed head read port when empty.
module pmipsl_fetch_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the read port is masked while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/pmipsl_fetch_unit.sv
// PMIPSL instruction fetch: owns the PC, requests imem and buffers
// {instr, PC+step} pairs for decode; a redirect flushes and re-steers the PC.
module pmipsl_fetch_unit
    import pmipsl_pkg::*;
#(
    parameter int unsigned        ADDR_W   = PMIPSL_ADDR_W,
    parameter int unsigned        INSTR_W  = PMIPSL_INSTR_W,
    parameter int unsigned        DEPTH    = 4,
    parameter int unsigned        PC_STEP  = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    output logic [ADDR_W-1:0]          imemaddr_o,
    output logic                       imemreq_o,
    input  logic                       imemready_i,
    input  logic [INSTR_W-1:0]         imemrdata_i,
    input  logic                       redirect_i,
    input  logic [ADDR_W-1:0]          redirectaddr_i,
    output logic                       idvalid_o,
    input  logic                       idready_i,
    output logic [INSTR_W-1:0]         idinstr_o,
    output logic [ADDR_W-1:0]          idpcplus_o,
    output logic [$clog2(DEPTH+1)-1:0] qcount_o
);

    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_plus;
    logic               pop;
    logic               accept;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head_entry;

    assign pc_plus = pc_q + ADDR_W'(PC_STEP);

    // Redirect dominates: the wrong-path head is hidden and nothing is fetched.
    assign idvalid_o  = ~fifo_empty & ~redirect_i;
    assign pop        = idvalid_o & idready_i;
    assign imemreq_o  = ~redirect_i & (~fifo_full | pop);
    assign accept     = imemreq_o & imemready_i;
    assign imemaddr_o = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirectaddr_i;
        end else if (accept) begin
            pc_d = pc_plus;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    pmipsl_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (accept),
        .wdata_i ({imemrdata_i, pc_plus}),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .count_o (qcount_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {idinstr_o, idpcplus_o} = head_entry;

endmodule

// File: tb/tb_pmipsl_fetch_unit.sv
// Randomised and directed bench for pmipsl_fetch_unit against a queue-based model.
module tb_pmipsl_fetch_unit;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 17;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PC_STEP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n = 1'b1;
    logic [ADDR_W-1:0]   imemaddr;
    logic                imemreq;
    logic                imemready = 1'b0;
    logic [INSTR_W-1:0]  imemrdata = '0;
    logic                redirect = 1'b0;
    logic [ADDR_W-1:0]   redirectaddr = '0;
    logic                idvalid;
    logic                idready = 1'b0;
    logic [INSTR_W-1:0]  idinstr;
    logic [ADDR_W-1:0]   idpcplus;
    logic [2:0]          qcount;

    logic                w_rst_n = 1'b1;
    logic [ADDR_W-1:0]   w_imemaddr;
    logic                w_imemreq;
    logic                w_imemready = 1'b0;
    logic [INSTR_W-1:0]  w_imemrdata = 17'h00155;
    logic                w_redirect = 1'b0;
    logic [ADDR_W-1:0]   w_redirectaddr = '0;
    logic                w_idvalid;
    logic                w_idready = 1'b0;
    logic [INSTR_W-1:0]  w_idinstr;
    logic [ADDR_W-1:0]   w_idpcplus;
    logic [2:0]          w_qcount;

    pmipsl_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .PC_STEP  (PC_STEP),
        .RESET_PC (16'h0000)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .imemaddr_o     (imemaddr),
        .imemreq_o      (imemreq),
        .imemready_i    (imemready),
        .imemrdata_i    (imemrdata),
        .redirect_i     (redirect),
        .redirectaddr_i (redirectaddr),
        .idvalid_o      (idvalid),
        .idready_i      (idready),
        .idinstr_o      (idinstr),
        .idpcplus_o     (idpcplus),
        .qcount_o       (qcount)
    );

    pmipsl_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .PC_STEP  (PC_STEP),
        .RESET_PC (16'hFFFC)
    ) dut_wrap (
        .clk_i          (clk),
        .rst_ni         (w_rst_n),
        .imemaddr_o     (w_imemaddr),
        .imemreq_o      (w_imemreq),
        .imemready_i    (w_imemready),
        .imemrdata_i    (w_imemrdata),
        .redirect_i     (w_redirect),
        .redirectaddr_i (w_redirectaddr),
        .idvalid_o      (w_idvalid),
        .idready_i      (w_idready),
        .idinstr_o      (w_idinstr),
        .idpcplus_o     (w_idpcplus),
        .qcount_o       (w_qcount)
    );

    typedef struct {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pcplus;
    } ent_t;

    ent_t              mq[$];
    logic [ADDR_W-1:0] mpc;
    int                n_tests = 0;
    int                n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs with the model, then advance the model.
    task automatic cycle(input bit rdy, input bit idr, input bit redir,
                         input logic [ADDR_W-1:0] raddr, input logic [INSTR_W-1:0] rdata);
        bit   ev, ep, er, ea;
        ent_t head;
        imemready    = rdy;
        idready      = idr;
        redirect     = redir;
        redirectaddr = raddr;
        imemrdata    = rdata;
        #1;
        ev = (mq.size() != 0) && !redir;
        ep = ev && idr;
        er = !redir && ((mq.size() < DEPTH) || ep);
        ea = er && rdy;
        head.instr  = '0;
        head.pcplus = '0;
        if (mq.size() != 0) head = mq[0];
        check_eq("imemaddr", 32'(imemaddr), 32'(mpc));
        check_eq("imemreq",  32'(imemreq),  32'(er));
        check_eq("idvalid",  32'(idvalid),  32'(ev));
        check_eq("qcount",   32'(qcount),   32'(mq.size()));
        check_eq("idinstr",  32'(idinstr),  32'(head.instr));
        check_eq("idpcplus", 32'(idpcplus), 32'(head.pcplus));
        @(posedge clk);
        if (redir) begin
            mq.delete();
            mpc = raddr;
        end else begin
            if (ep) void'(mq.pop_front());
            if (ea) begin
                head.instr  = rdata;
                head.pcplus = mpc + ADDR_W'(PC_STEP);
                mq.push_back(head);
                mpc = mpc + ADDR_W'(PC_STEP);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        imemready    = 1'b0;
        idready      = 1'b0;
        redirect     = 1'b0;
        redirectaddr = '0;
        imemrdata    = '0;
        rst_n        = 1'b0;
        mq.delete();
        mpc = '0;
        #1;
        check_eq("rst_idvalid",  32'(idvalid),  32'(0));
        check_eq("rst_qcount",   32'(qcount),   32'(0));
        check_eq("rst_imemaddr", 32'(imemaddr), 32'(16'h0000));
        check_eq("rst_idinstr",  32'(idinstr),  32'(0));
        check_eq("rst_idpcplus", 32'(idpcplus), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [INSTR_W-1:0] rnd_instr();
        return INSTR_W'($urandom);
    endfunction

    initial begin
        logic [ADDR_W-1:0] held;
        #1 w_rst_n = 1'b0;
        #1;

        // Streaming at one instruction per cycle.
        do_reset();
        repeat (6) cycle(1'b1, 1'b1, 1'b0, '0, rnd_instr());
        check_eq("t1_qcount", 32'(qcount), 32'(1));

        // Decode stalled: queue fills and fetch stops at PC=8.
        do_reset();
        repeat (6) cycle(1'b1, 1'b0, 1'b0, '0, rnd_instr());
        check_eq("t2_imemreq",  32'(imemreq),  32'(0));
        check_eq("t2_imemaddr", 32'(imemaddr), 32'(16'h0008));
        check_eq("t2_qcount",   32'(qcount),   32'(4));
        cycle(1'b1, 1'b1, 1'b0, '0, rnd_instr());
        check_eq("t2_qcount_pp",   32'(qcount),   32'(4));
        check_eq("t2_imemaddr_pp", 32'(imemaddr), 32'(16'h000A));

        // Redirect with three queued entries.
        do_reset();
        repeat (3) cycle(1'b1, 1'b0, 1'b0, '0, rnd_instr());
        check_eq("t3_qcount_pre", 32'(qcount), 32'(3));
        cycle(1'b1, 1'b1, 1'b1, 16'h0100, rnd_instr());
        check_eq("t3_qcount_post", 32'(qcount),   32'(0));
        check_eq("t3_imemaddr",    32'(imemaddr), 32'(16'h0100));
        cycle(1'b1, 1'b1, 1'b0, '0, rnd_instr());
        check_eq("t3_idpcplus", 32'(idpcplus), 32'(16'h0102));
        cycle(1'b1, 1'b0, 1'b0, '0, rnd_instr());

        // imem wait states: address holds, queue only drains.
        held = imemaddr;
        repeat (3) cycle(1'b0, 1'b1, 1'b0, '0, rnd_instr());
        check_eq("t4_addr_hold", 32'(imemaddr), 32'(held));
        check_eq("t4_qcount",    32'(qcount),   32'(0));

        // Back-to-back redirects: the last target wins.
        cycle(1'b1, 1'b1, 1'b1, 16'h2000, rnd_instr());
        cycle(1'b1, 1'b1, 1'b1, 16'h3000, rnd_instr());
        check_eq("bb_imemaddr", 32'(imemaddr), 32'(16'h3000));
        repeat (3) cycle(1'b1, 1'b1, 1'b0, '0, rnd_instr());

        // PC wrap from a non-zero reset vector.
        w_imemready = 1'b1;
        w_idready   = 1'b1;
        @(negedge clk);
        w_rst_n = 1'b1;
        #1;
        check_eq("t5_addr0", 32'(w_imemaddr), 32'(16'hFFFC));
        @(posedge clk); #1;
        check_eq("t5_addr1", 32'(w_imemaddr), 32'(16'hFFFE));
        check_eq("t5_pc1",   32'(w_idpcplus), 32'(16'hFFFE));
        @(posedge clk); #1;
        check_eq("t5_addr2", 32'(w_imemaddr), 32'(16'h0000));
        check_eq("t5_pc2",   32'(w_idpcplus), 32'(16'h0000));
        @(posedge clk); #1;
        check_eq("t5_pc3",   32'(w_idpcplus), 32'(16'h0002));

        // Asynchronous reset mid-cycle with two entries queued.
        do_reset();
        repeat (2) cycle(1'b1, 1'b0, 1'b0, '0, rnd_instr());
        check_eq("t6_qcount_pre", 32'(qcount), 32'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_idvalid",  32'(idvalid),  32'(0));
        check_eq("t6_qcount",   32'(qcount),   32'(0));
        check_eq("t6_imemaddr", 32'(imemaddr), 32'(16'h0000));
        mq.delete();
        mpc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, '0, rnd_instr());
        cycle(1'b1, 1'b1, 1'b0, '0, rnd_instr());

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bit rdy, idr, redir;
            rdy   = ($urandom_range(0, 3) != 0);
            idr   = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 19) == 0);
            cycle(rdy, idr, redir, ADDR_W'($urandom), rnd_instr());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
